tensor_core_sequencer: RTL and testbench

// - Sequences one tensor-core operation end to end.
// - Load: accepts 18 int8 operands (two 3x3 matrices, row-major, matrix 0 first) on a valid/ready stream.

---
 rtl/tensor_core_sequencer_if.sv | 41 ++++
 rtl/tensor_core_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_tensor_core_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tensor_core_sequencer_if.sv
// Bus bundle between the tensor core sequencer and its host stream, result stream,
// register file and tensor core. The master modport is the sequencer side.
interface tensor_core_sequencer_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic                              in_valid_in;
   logic signed [DATA_WIDTH-1:0]      in_data_in;
   logic                              in_ready_out;
   logic                              out_valid_out;
   logic signed [DATA_WIDTH-1:0]      out_data_out;
   logic                              out_last_out;
   logic                              out_ready_in;
   logic                              rf_quad_write_enable_out;
   logic [2:0]                        rf_quad_write_address_out;
   logic [3:0][DATA_WIDTH-1:0]        rf_quad_write_data_out;
   logic                              rf_non_bulk_write_enable_out;
   logic [4:0]                        rf_non_bulk_write_address_out;
   logic signed [DATA_WIDTH-1:0]      rf_non_bulk_write_data_out;
   logic [4:0]                        rf_non_bulk_read_address_out;
   logic signed [DATA_WIDTH-1:0]      rf_non_bulk_read_data_in;
   logic                              compute_start_out;
   logic                              compute_done_in;
   logic                              busy_out;
   logic                              timeout_error_out;

   modport master (
      input  in_valid_in, in_data_in, out_ready_in, rf_non_bulk_read_data_in, compute_done_in,
      output in_ready_out, out_valid_out, out_data_out, out_last_out,
             rf_quad_write_enable_out, rf_quad_write_address_out, rf_quad_write_data_out,
             rf_non_bulk_write_enable_out, rf_non_bulk_write_address_out, rf_non_bulk_write_data_out,
             rf_non_bulk_read_address_out, compute_start_out, busy_out, timeout_error_out
   );

   modport slave (
      output in_valid_in, in_data_in, out_ready_in, rf_non_bulk_read_data_in, compute_done_in,
      input  in_ready_out, out_valid_out, out_data_out, out_last_out,
             rf_quad_write_enable_out, rf_quad_write_address_out, rf_quad_write_data_out,
             rf_non_bulk_write_enable_out, rf_non_bulk_write_address_out, rf_non_bulk_write_data_out,
             rf_non_bulk_read_address_out, compute_start_out, busy_out, timeout_error_out
   );
endinterface

// File: rtl/tensor_core_sequencer.sv
// Loads 18 operands into the tensor core register file, starts the core, then drains results.
// Define TENSOR_SEQ_TIMEOUT_EN to add the WAIT_DONE watchdog and sticky timeout_error_out.
module tensor_core_sequencer #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned RESULT_BASE    = 0,
   parameter int unsigned RESULT_COUNT   = 9,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                   clock_in,
   input  logic                   reset_in,
   tensor_core_sequencer_if.master bus
);
   localparam int unsigned CntW     = 5;
   localparam int unsigned LastElem = 17;

   if (RESULT_COUNT == 0 || RESULT_BASE + RESULT_COUNT > 18 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
      $error("tensor_core_sequencer: illegal RESULT_BASE/RESULT_COUNT/TIMEOUT_CYCLES");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_FLUSH, S_START, S_WAIT_DONE, S_DRAIN
   } state_t;

   state_t                     state_q, state_d;
   logic [CntW-1:0]            cnt_q, cnt_d;
   logic [2:0][DATA_WIDTH-1:0] buf_q, buf_d;
   logic                       qwe_q, qwe_d;
   logic [2:0]                 qaddr_q, qaddr_d;
   logic [3:0][DATA_WIDTH-1:0] qdata_q, qdata_d;
   logic                       nwe_q, nwe_d;
   logic [4:0]                 naddr_q, naddr_d;
   logic [DATA_WIDTH-1:0]      ndata_q, ndata_d;
   logic [4:0]                 raddr_q, raddr_d;
   logic [CntW-1:0]            idx_q, idx_d;
   logic                       valid_q, valid_d;
   logic                       last_q, last_d;
   logic                       start_q, start_d;
   logic                       busy_q, busy_d;
   logic                       in_ready;
   logic                       accept;
   logic                       xfer;
`ifdef TENSOR_SEQ_TIMEOUT_EN
   localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TimeoutW-1:0]        tmo_cnt_q, tmo_cnt_d;
   logic                       tmo_err_q, tmo_err_d;
`endif

   assign in_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
   assign accept   = bus.in_valid_in && in_ready;
   assign xfer     = valid_q && bus.out_ready_in;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      qwe_d   = 1'b0;
      qaddr_d = qaddr_q;
      qdata_d = qdata_q;
      nwe_d   = 1'b0;
      naddr_d = naddr_q;
      ndata_d = ndata_q;
      raddr_d = raddr_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      last_d  = last_q;
      start_d = 1'b0;
`ifdef TENSOR_SEQ_TIMEOUT_EN
      tmo_cnt_d = tmo_cnt_q;
      tmo_err_d = tmo_err_q;
`endif
      case (state_q)
         S_IDLE, S_LOAD: begin
            if (accept) begin
               // Elements 0..15 gather into quads; 16 and 17 go out as single writes
               if (!cnt_q[4]) begin
                  if (cnt_q[1:0] == 2'd3) begin
                     qwe_d   = 1'b1;
                     qaddr_d = 3'(cnt_q[3:2]);
                     qdata_d = {bus.in_data_in, buf_q[2], buf_q[1], buf_q[0]};
                     buf_d   = '0;
                  end else begin
                     buf_d[cnt_q[1:0]] = bus.in_data_in;
                  end
               end else begin
                  nwe_d   = 1'b1;
                  naddr_d = cnt_q;
                  ndata_d = bus.in_data_in;
               end
               if (cnt_q == CntW'(LastElem)) begin
                  cnt_d   = '0;
                  state_d = S_FLUSH;
               end else begin
                  cnt_d   = cnt_q + CntW'(1);
                  state_d = S_LOAD;
               end
            end
         end
         S_FLUSH: begin
            state_d = S_START;
            start_d = 1'b1;
         end
         S_START: begin
            state_d = S_WAIT_DONE;
`ifdef TENSOR_SEQ_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
         end
         S_WAIT_DONE: begin
            if (bus.compute_done_in) begin
               state_d = S_DRAIN;
               valid_d = 1'b1;
               idx_d   = '0;
               raddr_d = 5'(RESULT_BASE);
               last_d  = (RESULT_COUNT == 1);
            end
`ifdef TENSOR_SEQ_TIMEOUT_EN
            else if (tmo_cnt_q == TimeoutW'(TIMEOUT_CYCLES - 1)) begin
               tmo_err_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TimeoutW'(1);
            end
`endif
         end
         S_DRAIN: begin
            if (xfer) begin
               if (last_q) begin
                  state_d = S_IDLE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  idx_d   = '0;
                  raddr_d = '0;
               end else begin
                  idx_d   = idx_q + CntW'(1);
                  raddr_d = raddr_q + 5'd1;
                  last_d  = (idx_q + CntW'(1) == CntW'(RESULT_COUNT - 1));
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         buf_q   <= '0;
         qwe_q   <= 1'b0;
         qaddr_q <= '0;
         qdata_q <= '0;
         nwe_q   <= 1'b0;
         naddr_q <= '0;
         ndata_q <= '0;
         raddr_q <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
`ifdef TENSOR_SEQ_TIMEOUT_EN
         tmo_cnt_q <= '0;
         tmo_err_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         qwe_q   <= qwe_d;
         qaddr_q <= qaddr_d;
         qdata_q <= qdata_d;
         nwe_q   <= nwe_d;
         naddr_q <= naddr_d;
         ndata_q <= ndata_d;
         raddr_q <= raddr_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         start_q <= start_d;
         busy_q  <= busy_d;
`ifdef TENSOR_SEQ_TIMEOUT_EN
         tmo_cnt_q <= tmo_cnt_d;
         tmo_err_q <= tmo_err_d;
`endif
      end
   end

   assign bus.in_ready_out                  = in_ready;
   assign bus.out_valid_out                 = valid_q;
   // Result data is the register file read port, gated so it reads zero outside DRAIN
   assign bus.out_data_out                  = valid_q ? bus.rf_non_bulk_read_data_in : '0;
   assign bus.out_last_out                  = last_q;
   assign bus.rf_quad_write_enable_out      = qwe_q;
   assign bus.rf_quad_write_address_out     = qaddr_q;
   assign bus.rf_quad_write_data_out        = qdata_q;
   assign bus.rf_non_bulk_write_enable_out  = nwe_q;
   assign bus.rf_non_bulk_write_address_out = naddr_q;
   assign bus.rf_non_bulk_write_data_out    = ndata_q;
   assign bus.rf_non_bulk_read_address_out  = raddr_q;
   assign bus.compute_start_out             = start_q;
   assign bus.busy_out                      = busy_q;
`ifdef TENSOR_SEQ_TIMEOUT_EN
   assign bus.timeout_error_out             = tmo_err_q;
`else
   assign bus.timeout_error_out             = 1'b0;
`endif
endmodule

// File: tb/tb_tensor_core_sequencer.sv
// Scoreboard bench for tensor_core_sequencer: load, compute handshake, drain, reset and watchdog.
module tb_tensor_core_sequencer;
   localparam int unsigned RBase  = 0;
   localparam int unsigned RCount = 9;

   typedef struct packed {
      logic        quad;
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;
   wr_t  wq[$];
   res_t rq[$];

   tensor_core_sequencer_if #(.DATA_WIDTH(8)) bus ();

   tensor_core_sequencer #(
      .DATA_WIDTH(8), .RESULT_BASE(RBase), .RESULT_COUNT(RCount), .TIMEOUT_CYCLES(10)
   ) dut (
      .clock_in(clk),
      .reset_in(rst),
      .bus     (bus.master)
   );

   always #5 clk = ~clk;

   // Register file read model: each flat index reads back as twice its index
   assign bus.rf_non_bulk_read_data_in = 8'(bus.rf_non_bulk_read_address_out) * 8'd2;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      vectors++;
      if (bus.out_valid_out !== 1'b0 || bus.busy_out !== 1'b0 || bus.compute_start_out !== 1'b0 ||
          bus.rf_quad_write_enable_out !== 1'b0 || bus.rf_non_bulk_write_enable_out !== 1'b0 ||
          bus.timeout_error_out !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_strobes: valid=%b busy=%b start=%b qwe=%b nwe=%b tmo=%b want all 0",
                  bus.out_valid_out, bus.busy_out, bus.compute_start_out,
                  bus.rf_quad_write_enable_out, bus.rf_non_bulk_write_enable_out, bus.timeout_error_out);
      end
      tick();
      tick();
      rst = 1'b0;
      tick();
      vectors++;
      if (bus.in_ready_out !== 1'b1 || bus.rf_non_bulk_read_address_out !== 5'd0 ||
          bus.out_data_out !== 8'sd0 || bus.out_last_out !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: ready=%b raddr=%0d data=%0d last=%b want 1,0,0,0",
                  bus.in_ready_out, bus.rf_non_bulk_read_address_out, bus.out_data_out, bus.out_last_out);
      end
   endtask

   task automatic test_load(input int base, input bit gaps, input bit pulse_done);
      logic [31:0] qacc;
      wr_t         w;
      qacc = '0;
      for (int e = 0; e < 18; e++) begin
         if (gaps) begin
            int g;
            g = int'($urandom_range(0, 2));
            for (int k = 0; k < g; k++) begin
               bus.in_valid_in = 1'b0;
               tick();
               vectors++;
               if (bus.rf_quad_write_enable_out !== 1'b0 || bus.rf_non_bulk_write_enable_out !== 1'b0) begin
                  miscompares++;
                  $display("FAIL gap_strobe e=%0d: qwe=%b nwe=%b want 0,0", e,
                           bus.rf_quad_write_enable_out, bus.rf_non_bulk_write_enable_out);
               end
            end
         end
         if (pulse_done && e == 5) bus.compute_done_in = 1'b1;
         bus.in_valid_in = 1'b1;
         bus.in_data_in  = 8'(base + e);
         vectors++;
         if (bus.in_ready_out !== 1'b1) begin
            miscompares++;
            $display("FAIL load_ready e=%0d: got %b want 1", e, bus.in_ready_out);
         end
         if (e < 16) begin
            qacc[(e % 4) * 8 +: 8] = 8'(base + e);
            if (e % 4 == 3) begin
               wq.push_back('{quad: 1'b1, addr: 5'(e / 4), data: qacc});
               qacc = '0;
            end
         end else begin
            wq.push_back('{quad: 1'b0, addr: 5'(e), data: 32'(8'(base + e))});
         end
         tick();
         bus.compute_done_in = 1'b0;
         if (e == 0) begin
            vectors++;
            if (bus.busy_out !== 1'b1) begin
               miscompares++;
               $display("FAIL busy_first_accept: got %b want 1", bus.busy_out);
            end
         end
         if (wq.size() > 0) begin
            w = wq.pop_front();
            vectors++;
            if (w.quad) begin
               if (bus.rf_quad_write_enable_out !== 1'b1 || bus.rf_non_bulk_write_enable_out !== 1'b0 ||
                   5'(bus.rf_quad_write_address_out) !== w.addr || 32'(bus.rf_quad_write_data_out) !== w.data) begin
                  miscompares++;
                  $display("FAIL quad_write e=%0d: we=%b nwe=%b addr=%0d data=%h want 1,0,%0d,%h", e,
                           bus.rf_quad_write_enable_out, bus.rf_non_bulk_write_enable_out,
                           bus.rf_quad_write_address_out, 32'(bus.rf_quad_write_data_out), w.addr, w.data);
               end
            end else begin
               if (bus.rf_non_bulk_write_enable_out !== 1'b1 || bus.rf_quad_write_enable_out !== 1'b0 ||
                   bus.rf_non_bulk_write_address_out !== w.addr ||
                   8'(bus.rf_non_bulk_write_data_out) !== w.data[7:0]) begin
                  miscompares++;
                  $display("FAIL single_write e=%0d: we=%b qwe=%b addr=%0d data=%0d want 1,0,%0d,%0d", e,
                           bus.rf_non_bulk_write_enable_out, bus.rf_quad_write_enable_out,
                           bus.rf_non_bulk_write_address_out, bus.rf_non_bulk_write_data_out, w.addr, w.data[7:0]);
               end
            end
         end else begin
            vectors++;
            if (bus.rf_quad_write_enable_out !== 1'b0 || bus.rf_non_bulk_write_enable_out !== 1'b0) begin
               miscompares++;
               $display("FAIL spurious_write e=%0d: qwe=%b nwe=%b want 0,0", e,
                        bus.rf_quad_write_enable_out, bus.rf_non_bulk_write_enable_out);
            end
         end
      end
      // FLUSH: input stream must be closed even with valid still high
      vectors++;
      if (bus.in_ready_out !== 1'b0 || bus.compute_start_out !== 1'b0) begin
         miscompares++;
         $display("FAIL flush: ready=%b start=%b want 0,0", bus.in_ready_out, bus.compute_start_out);
      end
      tick();
      vectors++;
      if (bus.compute_start_out !== 1'b1 || bus.rf_non_bulk_write_enable_out !== 1'b0 ||
          bus.rf_quad_write_enable_out !== 1'b0 || bus.in_ready_out !== 1'b0) begin
         miscompares++;
         $display("FAIL start_pulse: start=%b nwe=%b qwe=%b ready=%b want 1,0,0,0", bus.compute_start_out,
                  bus.rf_non_bulk_write_enable_out, bus.rf_quad_write_enable_out, bus.in_ready_out);
      end
      if (pulse_done) bus.compute_done_in = 1'b1;
      tick();
      bus.compute_done_in = 1'b0;
      bus.in_valid_in     = 1'b0;
      vectors++;
      if (bus.compute_start_out !== 1'b0 || bus.busy_out !== 1'b1 || bus.out_valid_out !== 1'b0) begin
         miscompares++;
         $display("FAIL start_end: start=%b busy=%b valid=%b want 0,1,0", bus.compute_start_out,
                  bus.busy_out, bus.out_valid_out);
      end
   endtask

   task automatic test_drain(input int done_delay, input int stall_at, input int stop_after);
      res_t r;
      int   sent;
      int   stalls;
      logic rdy;
      for (int i = 0; i < done_delay; i++) begin
         vectors++;
         if (bus.out_valid_out !== 1'b0 || bus.busy_out !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_done c=%0d: valid=%b busy=%b want 0,1", i, bus.out_valid_out, bus.busy_out);
         end
         tick();
      end
      bus.compute_done_in = 1'b1;
      for (int i = 0; i < int'(RCount); i++)
         rq.push_back('{data: 8'((int'(RBase) + i) * 2), last: (i == int'(RCount) - 1)});
      tick();
      bus.compute_done_in = 1'b0;
      sent   = 0;
      stalls = 0;
      for (int cyc = 0; cyc < 100 && rq.size() > 0; cyc++) begin
         if (stop_after >= 0 && sent == stop_after) break;
         r = rq[0];
         vectors++;
         if (bus.out_valid_out !== 1'b1 || 8'(bus.out_data_out) !== r.data || bus.out_last_out !== r.last) begin
            miscompares++;
            $display("FAIL result n=%0d: valid=%b data=%0d last=%b want 1,%0d,%b", sent,
                     bus.out_valid_out, bus.out_data_out, bus.out_last_out, r.data, r.last);
         end
         rdy = !(sent == stall_at && stalls < 3);
         if (!rdy) stalls++;
         bus.out_ready_in = rdy;
         tick();
         if (rdy) begin
            void'(rq.pop_front());
            sent++;
         end
      end
      bus.out_ready_in = 1'b0;
      if (stop_after < 0) begin
         vectors++;
         if (rq.size() != 0 || bus.out_valid_out !== 1'b0 || bus.busy_out !== 1'b0 ||
             bus.in_ready_out !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_end: left=%0d valid=%b busy=%b ready=%b want 0,0,0,1", rq.size(),
                     bus.out_valid_out, bus.busy_out, bus.in_ready_out);
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      test_load(101, 1'b0, 1'b0);
      test_drain(5, -1, 4);
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (bus.out_valid_out !== 1'b0 || bus.out_data_out !== 8'sd0 || bus.out_last_out !== 1'b0 ||
          bus.rf_non_bulk_read_address_out !== 5'd0 || bus.busy_out !== 1'b0 ||
          bus.rf_quad_write_address_out !== 3'd0 || 32'(bus.rf_quad_write_data_out) !== 32'd0 ||
          bus.rf_non_bulk_write_address_out !== 5'd0 || bus.rf_non_bulk_write_data_out !== 8'sd0) begin
         miscompares++;
         $display("FAIL async_reset: valid=%b data=%0d last=%b raddr=%0d busy=%b qa=%0d na=%0d want all 0",
                  bus.out_valid_out, bus.out_data_out, bus.out_last_out, bus.rf_non_bulk_read_address_out,
                  bus.busy_out, bus.rf_quad_write_address_out, bus.rf_non_bulk_write_address_out);
      end
      rq.delete();
      tick();
      rst = 1'b0;
      tick();
      test_load(21, 1'b0, 1'b0);
      test_drain(5, 6, -1);
   endtask

   task automatic test_timeout();
      int n;
      test_load(41, 1'b0, 1'b0);
`ifdef TENSOR_SEQ_TIMEOUT_EN
      n = 0;
      while (bus.busy_out === 1'b1 && n < 50) begin
         vectors++;
         if (bus.out_valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_valid c=%0d: got %b want 0", n, bus.out_valid_out);
         end
         n++;
         tick();
      end
      vectors++;
      if (n != 10 || bus.timeout_error_out !== 1'b1 || bus.out_valid_out !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_fire: cycles=%0d err=%b valid=%b want 10,1,0", n,
                  bus.timeout_error_out, bus.out_valid_out);
      end
      bus.compute_done_in = 1'b1;
      tick();
      tick();
      bus.compute_done_in = 1'b0;
      vectors++;
      if (bus.timeout_error_out !== 1'b1 || bus.busy_out !== 1'b0 || bus.out_valid_out !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_sticky: err=%b busy=%b valid=%b want 1,0,0", bus.timeout_error_out,
                  bus.busy_out, bus.out_valid_out);
      end
      test_reset();
`else
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.busy_out !== 1'b1 || bus.out_valid_out !== 1'b0) n++;
         tick();
      end
      vectors++;
      if (n != 0 || bus.timeout_error_out !== 1'b0) begin
         miscompares++;
         $display("FAIL no_watchdog: bad_cycles=%0d err=%b want 0,0", n, bus.timeout_error_out);
      end
      test_drain(1, -1, -1);
`endif
   endtask

   initial begin
      rst                 = 1'b1;
      bus.in_valid_in     = 1'b0;
      bus.in_data_in      = '0;
      bus.out_ready_in    = 1'b0;
      bus.compute_done_in = 1'b0;
      test_reset();
      test_load(1, 1'b0, 1'b0);
      test_drain(5, 3, -1);
      test_load(61, 1'b1, 1'b0);
      test_drain(5, 0, -1);
      test_load(81, 1'b1, 1'b1);
      test_drain(8, 8, -1);
      test_reset_mid_drain();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, %0d miscompares so far", miscompares);
      $fatal(1, "global timeout");
   end
endmodule
